// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit buffer and its FIFO core.
package uart_pkg;
   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned DEFAULT_DEPTH = 16;

   typedef logic [BYTE_W-1:0] byte_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LAUNCH     = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } tx_state_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// System-side push port plus transmitter handshake for uart_tx_fifo.
interface uart_tx_fifo_if
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
);
   logic            wr_en;
   byte_t           wr_data;
   logic            full;
   logic            empty;
   logic [ADDR_W:0] level;
   logic            overflow;
   logic            transmit_enable;
   byte_t           data_in;
   logic            tx_busy;
   logic            idle;

   modport master (
      output wr_en, wr_data, tx_busy,
      input  full, empty, level, overflow, transmit_enable, data_in, idle
   );

   modport slave (
      input  wr_en, wr_data, tx_busy,
      output full, empty, level, overflow, transmit_enable, data_in, idle
   );
endinterface

// File: rtl/sync_fifo_core.sv
// Circular byte FIFO with registered level/full/empty flags and a drop-on-full
// overflow pulse.
module sync_fifo_core
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter int unsigned ADDR_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  byte_t           push_data_i,
   input  logic            pop_i,
   output byte_t           pop_data_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [ADDR_W:0] level_o,
   output logic            overflow_o
);
   localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

   byte_t             mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              full_q, empty_q, overflow_q;
   logic              do_push, do_pop;

   // Acceptance uses the registered flag, so a push while full is dropped
   // even when a pop frees a slot on the same edge.
   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= (level_d == FULL_LEVEL);
         empty_q    <= (level_d == '0);
         overflow_q <= push_i && full_q;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign level_o    = level_q;
   assign overflow_o = overflow_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer: queues system bytes and launches them one at a time into the
// UART transmitter, holding each byte on data_in for the whole frame.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH        = DEFAULT_DEPTH,
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned BUSY_TIMEOUT = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_fifo_if.slave  bus
);
   localparam int unsigned      CNT_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT - 1);

   tx_state_e        state_q;
   logic             te_q;
   byte_t            data_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fifo_empty;
   logic             pop;
   byte_t            pop_data;

   sync_fifo_core #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (bus.wr_en),
      .push_data_i (bus.wr_data),
      .pop_i       (pop),
      .pop_data_o  (pop_data),
      .full_o      (bus.full),
      .empty_o     (fifo_empty),
      .level_o     (bus.level),
      .overflow_o  (bus.overflow)
   );

   assign pop = (state_q == IDLE) && !fifo_empty && !bus.tx_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         te_q    <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         te_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  data_q  <= pop_data;
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: begin
               te_q    <= 1'b1;
               cnt_q   <= '0;
               state_q <= WAIT_START;
            end
            // A missed launch is retried with the same held byte, no new pop.
            WAIT_START: begin
               if (bus.tx_busy)         state_q <= WAIT_DONE;
               else if (cnt_q == CNT_MAX) state_q <= LAUNCH;
               else                     cnt_q   <= cnt_q + 1'b1;
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.empty           = fifo_empty;
   assign bus.transmit_enable = te_q;
   assign bus.data_in         = data_q;
   assign bus.idle            = fifo_empty && (state_q == IDLE) && !bus.tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo with a behavioural UART transmitter model.
module tb_uart_tx_fifo;
   import uart_pkg::*;

   localparam int unsigned DEPTH        = 16;
   localparam int unsigned ADDR_W       = 4;
   localparam int unsigned BUSY_TIMEOUT = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus();

   uart_tx_fifo #(
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W),
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int    vectors    = 0;
   int    miscompares = 0;
   int    cyc        = 0;

   byte_t exp_q[$];
   byte_t rx_q[$];
   int    te_cyc_q[$];
   byte_t te_data_q[$];
   int    te_level_q[$];
   int    te_cnt     = 0;
   int    frame_len  = 4;
   int    ignore_cnt = 0;
   int    busy_cnt   = 0;
   bit    force_busy = 1'b0;
   byte_t cur_byte   = '0;
   int    stable_err = 0;
   int    ovf_cnt    = 0;
   int    peak_level = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: acts on each falling edge, sees transmit_enable pulses,
   // latches the byte and holds tx_busy for frame_len cycles.
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.transmit_enable === 1'b1) begin
            te_cnt++;
            te_cyc_q.push_back(cyc);
            te_data_q.push_back(bus.data_in);
            te_level_q.push_back(int'(bus.level));
         end
         if (int'(bus.level) > peak_level) peak_level = int'(bus.level);
         if (bus.overflow === 1'b1) ovf_cnt++;
         if (!rst_n) begin
            busy_cnt    = 0;
            bus.tx_busy = 1'b0;
         end else if (force_busy) begin
            bus.tx_busy = 1'b1;
         end else if (busy_cnt > 0) begin
            if (bus.data_in !== cur_byte) stable_err++;
            busy_cnt--;
            if (busy_cnt == 0) bus.tx_busy = 1'b0;
         end else if (bus.transmit_enable === 1'b1) begin
            if (ignore_cnt > 0) begin
               ignore_cnt--;
            end else begin
               cur_byte = bus.data_in;
               rx_q.push_back(bus.data_in);
               busy_cnt    = frame_len;
               bus.tx_busy = 1'b1;
            end
         end else begin
            bus.tx_busy = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_byte(input byte_t b);
      bus.wr_data = b;
      bus.wr_en   = 1'b1;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      rx_q.delete();
      te_cyc_q.delete();
      te_data_q.delete();
      te_level_q.delete();
      stable_err = 0;
      ovf_cnt    = 0;
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int n = 0;
      while (bus.idle !== 1'b1 && n < max_cyc) begin
         step();
         n++;
      end
      vectors++;
      if (bus.idle !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_idle_timeout: idle=%b required 1 within %0d cycles", tag, bus.idle, max_cyc);
      end
   endtask

   task automatic check_stream(input string tag);
      vectors++;
      if (rx_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s_count: received %0d bytes, required %0d", tag, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         vectors++;
         if (rx_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s_byte%0d: received %02h, required %02h", tag, i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      repeat (3) step();
      vectors += 7;
      if (bus.empty !== 1'b1)           begin miscompares++; $display("FAIL rst_empty: got %b required 1", bus.empty); end
      if (bus.full !== 1'b0)            begin miscompares++; $display("FAIL rst_full: got %b required 0", bus.full); end
      if (bus.level !== '0)             begin miscompares++; $display("FAIL rst_level: got %0d required 0", bus.level); end
      if (bus.overflow !== 1'b0)        begin miscompares++; $display("FAIL rst_overflow: got %b required 0", bus.overflow); end
      if (bus.transmit_enable !== 1'b0) begin miscompares++; $display("FAIL rst_te: got %b required 0", bus.transmit_enable); end
      if (bus.data_in !== 8'h00)        begin miscompares++; $display("FAIL rst_data_in: got %02h required 00", bus.data_in); end
      if (bus.idle !== 1'b1)            begin miscompares++; $display("FAIL rst_idle: got %b required 1", bus.idle); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_byte();
      int t0;
      int push_cyc;
      clear_model();
      frame_len = 5208;
      t0 = te_cnt;
      push_byte(8'hA5);
      exp_q.push_back(8'hA5);
      push_cyc = cyc;
      repeat (50) step();
      vectors += 4;
      if (te_cyc_q.size() < 1) begin
         miscompares++;
         $display("FAIL single_latency: no transmit_enable seen, required one 2 cycles after push");
      end else if (te_cyc_q[0] - push_cyc != 2) begin
         miscompares++;
         $display("FAIL single_latency: got %0d cycles, required 2", te_cyc_q[0] - push_cyc);
      end
      if (te_data_q.size() < 1 || te_data_q[0] !== 8'hA5) begin
         miscompares++;
         $display("FAIL single_te_data: got %02h required a5", (te_data_q.size() > 0) ? te_data_q[0] : 8'h00);
      end
      if (bus.tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b required 1", bus.tx_busy); end
      if (bus.data_in !== 8'hA5) begin miscompares++; $display("FAIL single_hold: got %02h required a5", bus.data_in); end
      wait_idle(6000, "single");
      vectors += 2;
      if (te_cnt - t0 != 1) begin miscompares++; $display("FAIL single_pulses: got %0d required 1", te_cnt - t0); end
      if (stable_err != 0)  begin miscompares++; $display("FAIL single_stable: data_in changed %0d times, required 0", stable_err); end
      check_stream("single");
   endtask

   task automatic test_burst();
      int t0;
      clear_model();
      frame_len  = 20;
      peak_level = 0;
      t0 = te_cnt;
      for (int i = 1; i <= 5; i++) begin
         push_byte(byte_t'(i));
         exp_q.push_back(byte_t'(i));
      end
      wait_idle(500, "burst");
      vectors += 3;
      if (peak_level != 4)  begin miscompares++; $display("FAIL burst_peak: got %0d required 4", peak_level); end
      if (te_cnt - t0 != 5) begin miscompares++; $display("FAIL burst_pulses: got %0d required 5", te_cnt - t0); end
      if (stable_err != 0)  begin miscompares++; $display("FAIL burst_stable: got %0d required 0", stable_err); end
      check_stream("burst");
   endtask

   task automatic test_full_overflow();
      int    t0;
      byte_t b;
      clear_model();
      force_busy = 1'b1;
      repeat (2) step();
      t0 = te_cnt;
      repeat (4) step();
      vectors += 2;
      if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL ovf_pre_empty: got %b required 1", bus.empty); end
      if (te_cnt != t0)       begin miscompares++; $display("FAIL ovf_no_launch: got %0d pulses required 0", te_cnt - t0); end
      for (int i = 0; i < int'(DEPTH); i++) begin
         b = byte_t'($urandom_range(0, 255));
         push_byte(b);
         exp_q.push_back(b);
      end
      vectors += 3;
      if (bus.full !== 1'b1)     begin miscompares++; $display("FAIL ovf_full: got %b required 1", bus.full); end
      if (int'(bus.level) != 16) begin miscompares++; $display("FAIL ovf_level16: got %0d required 16", bus.level); end
      if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b required 0", bus.overflow); end
      push_byte(8'hEE);
      vectors += 2;
      if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse: got %b required 1", bus.overflow); end
      if (int'(bus.level) != 16) begin miscompares++; $display("FAIL ovf_level_kept: got %0d required 16", bus.level); end
      step();
      vectors++;
      if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_one_cycle: got %b required 0", bus.overflow); end
      frame_len  = 3;
      force_busy = 1'b0;
      wait_idle(800, "ovf");
      check_stream("ovf");
   endtask

   task automatic test_wraparound();
      byte_t b;
      clear_model();
      frame_len = 2;
      for (int i = 0; i < 40; i++) begin
         b = byte_t'($urandom_range(0, 255));
         push_byte(b);
         exp_q.push_back(b);
         repeat ($urandom_range(3, 9)) step();
      end
      wait_idle(1000, "wrap");
      vectors += 2;
      if (bus.level !== '0) begin miscompares++; $display("FAIL wrap_level: got %0d required 0", bus.level); end
      if (ovf_cnt != 0)     begin miscompares++; $display("FAIL wrap_overflow: got %0d pulses required 0", ovf_cnt); end
      check_stream("wrap");
   endtask

   task automatic test_timeout();
      int    t0;
      byte_t b;
      clear_model();
      frame_len  = 4;
      ignore_cnt = 1;
      b  = byte_t'($urandom_range(0, 255));
      t0 = te_cnt;
      push_byte(b);
      exp_q.push_back(b);
      wait_idle(200, "timeout");
      vectors++;
      if (te_cnt - t0 != 2) begin
         miscompares++;
         $display("FAIL timeout_pulses: got %0d required 2", te_cnt - t0);
      end else begin
         vectors += 4;
         if (te_cyc_q[1] - te_cyc_q[0] != int'(BUSY_TIMEOUT) + 1) begin
            miscompares++;
            $display("FAIL timeout_gap: got %0d cycles required %0d", te_cyc_q[1] - te_cyc_q[0], BUSY_TIMEOUT + 1);
         end
         if (te_data_q[0] !== b) begin miscompares++; $display("FAIL timeout_data0: got %02h required %02h", te_data_q[0], b); end
         if (te_data_q[1] !== b) begin miscompares++; $display("FAIL timeout_data1: got %02h required %02h", te_data_q[1], b); end
         if (te_level_q[0] != 0 || te_level_q[1] != 0) begin
            miscompares++;
            $display("FAIL timeout_level: got %0d/%0d required 0/0", te_level_q[0], te_level_q[1]);
         end
      end
      check_stream("timeout");
   endtask

   task automatic test_reset_midframe();
      int    n;
      int    t0;
      byte_t b;
      clear_model();
      frame_len = 300;
      for (int i = 0; i < 4; i++) push_byte(byte_t'($urandom_range(0, 255)));
      n = 0;
      while (!(bus.tx_busy === 1'b1 && int'(bus.level) == 3) && n < 50) begin
         step();
         n++;
      end
      vectors++;
      if (n >= 50) begin miscompares++; $display("FAIL rmf_setup: busy=%b level=%0d required 1/3", bus.tx_busy, bus.level); end
      repeat (3) step();
      #1 rst_n = 1'b0;
      #1;
      vectors += 5;
      if (bus.empty !== 1'b1)           begin miscompares++; $display("FAIL rmf_empty: got %b required 1", bus.empty); end
      if (bus.level !== '0)             begin miscompares++; $display("FAIL rmf_level: got %0d required 0", bus.level); end
      if (bus.full !== 1'b0)            begin miscompares++; $display("FAIL rmf_full: got %b required 0", bus.full); end
      if (bus.transmit_enable !== 1'b0) begin miscompares++; $display("FAIL rmf_te: got %b required 0", bus.transmit_enable); end
      if (bus.data_in !== 8'h00)        begin miscompares++; $display("FAIL rmf_data_in: got %02h required 00", bus.data_in); end
      repeat (2) step();
      rst_n = 1'b1;
      clear_model();
      t0 = te_cnt;
      repeat (30) step();
      vectors += 2;
      if (te_cnt != t0)      begin miscompares++; $display("FAIL rmf_no_launch: got %0d pulses required 0", te_cnt - t0); end
      if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL rmf_idle: got %b required 1", bus.idle); end
      frame_len = 3;
      b = byte_t'($urandom_range(0, 255));
      push_byte(b);
      exp_q.push_back(b);
      wait_idle(100, "rmf");
      vectors++;
      if (te_cnt - t0 != 1) begin miscompares++; $display("FAIL rmf_relaunch: got %0d pulses required 1", te_cnt - t0); end
      check_stream("rmf");
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      test_reset();
      test_single_byte();
      test_burst();
      test_full_overflow();
      test_wraparound();
      test_timeout();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
